// File: rtl/cfg_arb_pkg.sv
// Shared encodings and address-map constants for cfg_port_arbiter.
package cfg_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        ISSUE = 3'b010,
        RESP  = 3'b100
    } arb_state_e;

    localparam int unsigned CFG_ADDR_MAX   = 'h90;
    localparam int unsigned RO_ADDR_ID     = 'h80;
    localparam int unsigned RO_ADDR_STATUS = 'h8C;
    localparam int unsigned RO_ADDR_CAP    = 'h90;
    localparam int unsigned HOST_IDX       = 0;

endpackage

// File: rtl/cfg_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module cfg_arb_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    localparam logic [IDX_W:0] NREQ = (IDX_W + 1)'(NUM_REQ);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            // ptr + off reduced modulo NUM_REQ without a divider
            sum = {1'b0, ptr_i} + (IDX_W + 1)'(off);
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            cand = sum[IDX_W-1:0];
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/cfg_port_arbiter.sv
// Arbitrates NUM_REQ requesters onto one register-bank config port with range/RO protection.
// Define CFG_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module cfg_port_arbiter
    import cfg_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REQ    = 2
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic                          rsp_err,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [ADDR_WIDTH-1:0]         cfg_addr,
    output logic [DATA_WIDTH-1:0]         cfg_wdata,
    output logic                          cfg_wr_en,
    output logic                          cfg_rd_en,
    input  logic [DATA_WIDTH-1:0]         cfg_rdata
);

    localparam int               IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W-1:0] HOST     = IDX_W'(HOST_IDX);

    arb_state_e                state_q;
    logic [IDX_W-1:0]          idx_q;
    logic                      wr_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [NUM_REQ-1:0]        rsp_valid_q;
    logic                      rsp_err_q;
    logic                      rsp_rd_q;

    logic [NUM_REQ-1:0]        gnt;
    logic [IDX_W-1:0]          gnt_idx;
    logic                      gnt_any;
    logic [IDX_W-1:0]          pick_ptr;

    logic                      sel_wr;
    logic [ADDR_WIDTH-1:0]     sel_addr;
    logic [DATA_WIDTH-1:0]     sel_wdata;
    logic [NUM_REQ-1:0]        idx_oh;

    logic                      addr_err;
    logic                      ro_hit;
    logic                      err;

`ifdef CFG_ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [IDX_W-1:0]          ptr_q;
    logic [IDX_W-1:0]          ptr_d;

    assign pick_ptr = ptr_q;
    assign ptr_d    = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
`endif

    cfg_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (pick_ptr),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        idx_oh    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_wr    = req_write[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (idx_q == IDX_W'(i)) begin
                idx_oh[i] = 1'b1;
            end
        end
    end

    // Only the host is barred from the read-only status words; engines report through them.
    assign addr_err = (addr_q > ADDR_WIDTH'(CFG_ADDR_MAX)) || (addr_q[1:0] != 2'b00);
    assign ro_hit   = (addr_q == ADDR_WIDTH'(RO_ADDR_ID))
                   || (addr_q == ADDR_WIDTH'(RO_ADDR_STATUS))
                   || (addr_q == ADDR_WIDTH'(RO_ADDR_CAP));
    assign err      = addr_err || (wr_q && ro_hit && (idx_q == HOST));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rd_q    <= 1'b0;
`ifndef CFG_ARB_FIXED_PRIO_EN
            ptr_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        idx_q   <= gnt_idx;
                        wr_q    <= sel_wr;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_valid_q <= idx_oh;
                    rsp_err_q   <= err;
                    rsp_rd_q    <= !wr_q && !err;
                    state_q     <= RESP;
                end
                RESP: begin
                    rsp_valid_q <= '0;
                    rsp_err_q   <= 1'b0;
                    rsp_rd_q    <= 1'b0;
`ifndef CFG_ARB_FIXED_PRIO_EN
                    ptr_q       <= ptr_d;
`endif
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from state so an async reset drops them in the same instant.
    assign cfg_wr_en = (state_q == ISSUE) && wr_q && !err;
    assign cfg_rd_en = (state_q == ISSUE) && !wr_q && !err;
    assign cfg_addr  = addr_q;
    assign cfg_wdata = wdata_q;

    assign req_ready = (PRESETn && (state_q == IDLE)) ? gnt : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rd_q ? cfg_rdata : '0;

endmodule

// File: tb/tb_cfg_port_arbiter.sv
// Directed bench for cfg_port_arbiter: latency, protection, arbitration order and reset abort.
module tb_cfg_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NR = 2;

    logic             PCLK = 1'b0;
    logic             PRESETn;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_write;
    logic [AW-1:0]    a0, a1;
    logic [DW-1:0]    d0, d1;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    rsp_valid;
    logic             rsp_err;
    logic [DW-1:0]    rsp_rdata;
    logic [AW-1:0]    cfg_addr;
    logic [DW-1:0]    cfg_wdata;
    logic             cfg_wr_en;
    logic             cfg_rd_en;
    logic [DW-1:0]    cfg_rdata;

    int total = 0;
    int bad   = 0;

    assign req_addr  = {a1, a0};
    assign req_wdata = {d1, d0};

    always #5 PCLK = ~PCLK;

    cfg_port_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REQ    (NR)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_wr_en (cfg_wr_en),
        .cfg_rd_en (cfg_rd_en),
        .cfg_rdata (cfg_rdata)
    );

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One isolated access by requester r, starting in an IDLE cycle.
    task automatic single(input string tag, input int r, input logic wr,
                          input logic [31:0] ad, input logic [31:0] wd,
                          input logic exp_err, input logic [31:0] exp_rdata);
        logic [NR-1:0] oh;
        oh        = NR'(1 << r);
        req_valid = oh;
        req_write = wr ? oh : '0;
        if (r == 0) begin
            a0 = ad;
            d0 = wd;
        end else begin
            a1 = ad;
            d1 = wd;
        end
        settle();
        chk({tag, "_ready"}, req_ready, oh);
        tick();
        req_valid = '0;
        settle();
        chk({tag, "_wr_en"}, cfg_wr_en, wr && !exp_err);
        chk({tag, "_rd_en"}, cfg_rd_en, !wr && !exp_err);
        chk({tag, "_addr"}, cfg_addr, ad);
        if (wr) chk({tag, "_wdata"}, cfg_wdata, wd);
        tick();
        chk({tag, "_rsp_valid"}, rsp_valid, oh);
        chk({tag, "_rsp_err"}, rsp_err, exp_err);
        chk({tag, "_rsp_rdata"}, rsp_rdata, exp_rdata);
        chk({tag, "_strobes_off"}, {cfg_wr_en, cfg_rd_en}, 2'b00);
        tick();
    endtask

    initial begin
        logic [NR-1:0] exp_g;

        PRESETn   = 1'b0;
        req_valid = 2'b01;
        req_write = '0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        cfg_rdata = 32'hA5A5_0001;
        tick();
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_cfg_addr", cfg_addr, 32'h0);
        chk("rst_cfg_wdata", cfg_wdata, 32'h0);
        chk("rst_strobes", {cfg_wr_en, cfg_rd_en}, 2'b00);
        req_valid = '0;
        PRESETn   = 1'b1;
        tick();

        single("rd10",  0, 1'b0, 32'h10, 32'h0,    1'b0, 32'hA5A5_0001);
        single("hwr8c", 0, 1'b1, 32'h8C, 32'hDEAD, 1'b1, 32'h0);
        single("ewr8c", 1, 1'b1, 32'h8C, 32'h1234, 1'b0, 32'h0);
        single("erd90", 1, 1'b0, 32'h90, 32'h0,    1'b0, 32'hA5A5_0001);
        single("rd94",  0, 1'b0, 32'h94, 32'h0,    1'b1, 32'h0);
        single("rd12",  0, 1'b0, 32'h12, 32'h0,    1'b1, 32'h0);

        // Reset asserted during ISSUE of a good host write
        a0 = 32'h20; d0 = 32'h55;
        req_write = 2'b01;
        req_valid = 2'b01;
        settle();
        chk("rmid_ready", req_ready, 2'b01);
        tick();
        req_valid = '0;
        PRESETn   = 1'b0;
        settle();
        chk("rmid_strobes", {cfg_wr_en, cfg_rd_en}, 2'b00);
        chk("rmid_cfg_addr", cfg_addr, 32'h0);
        chk("rmid_cfg_wdata", cfg_wdata, 32'h0);
        chk("rmid_rsp_valid", rsp_valid, 2'b00);
        tick();
        chk("rmid_rsp_valid2", rsp_valid, 2'b00);
        chk("rmid_rsp_err", rsp_err, 1'b0);
        PRESETn = 1'b1;
        tick();
        chk("rmid_idle_rsp", rsp_valid, 2'b00);

        // Both requesters continuously: pointer restarts at 0
        a0 = 32'h10; a1 = 32'h14;
        req_write = '0;
        req_valid = 2'b11;
        settle();
        for (int g = 0; g < 4; g++) begin
`ifdef CFG_ARB_FIXED_PRIO_EN
            exp_g = 2'b01;
`else
            exp_g = (g % 2 == 1) ? 2'b10 : 2'b01;
`endif
            chk($sformatf("cont%0d_ready", g), req_ready, exp_g);
            tick();
            chk($sformatf("cont%0d_ready_issue", g), req_ready, 2'b00);
            chk($sformatf("cont%0d_addr", g), cfg_addr, (exp_g == 2'b01) ? 32'h10 : 32'h14);
            chk($sformatf("cont%0d_rd_en", g), cfg_rd_en, 1'b1);
            tick();
            chk($sformatf("cont%0d_rsp_valid", g), rsp_valid, exp_g);
            chk($sformatf("cont%0d_ready_resp", g), req_ready, 2'b00);
            tick();
        end
        req_valid = '0;
        tick();

        // Request raised during another access's RESP waits for the next IDLE
        a0 = 32'h40;
        req_valid = 2'b01;
        settle();
        chk("late_first_ready", req_ready, 2'b01);
        tick();
        req_valid = '0;
        tick();
        a1 = 32'h44;
        req_valid = 2'b10;
        settle();
        chk("late_first_rsp", rsp_valid, 2'b01);
        chk("late_held", req_ready, 2'b00);
        tick();
        chk("late_grant", req_ready, 2'b10);
        tick();
        req_valid = '0;
        settle();
        chk("late_addr", cfg_addr, 32'h44);
        chk("late_rd_en", cfg_rd_en, 1'b1);
        tick();
        chk("late_rsp_valid", rsp_valid, 2'b10);
        chk("late_rdata", rsp_rdata, 32'hA5A5_0001);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
